// File: rtl/ram_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ram_loader
//  Description : Assembles a byte stream into 16-bit words (high byte first),
//                writes WORDS of them into RAM from BASE_ADDR upward, then
//                releases the CPU by raising cpu_en / done.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_loader #(
  parameter int          WORDS     = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        cpu_en,
  output logic        done
);

  typedef enum logic [1:0] {
    LOAD_HI = 2'd0,
    LOAD_LO = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Index of the final word; the extra bit lets WORDS=65536 be represented.
  localparam logic [16:0] LAST_IDX = 17'(WORDS - 1);

  state_t      state;
  logic [16:0] count;
  logic [7:0]  hi;
  logic [7:0]  lo;
  logic        xfer;

  assign xfer = byte_valid && byte_ready;

  // Loader FSM; every output is a register, so the write strobe and the
  // CPU release each appear one cycle after the state that produces them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= LOAD_HI;
      count      <= '0;
      hi         <= '0;
      lo         <= '0;
      byte_ready <= 1'b1;
      wr_en      <= 1'b0;
      wr_addr    <= BASE_ADDR;
      wr_data    <= '0;
      cpu_en     <= 1'b0;
      done       <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        LOAD_HI: begin
          if (xfer) begin
            hi    <= byte_in;
            state <= LOAD_LO;
          end
        end
        LOAD_LO: begin
          if (xfer) begin
            lo         <= byte_in;
            state      <= WRITE;
            byte_ready <= 1'b0;
          end
        end
        WRITE: begin
          wr_en   <= 1'b1;
          wr_addr <= BASE_ADDR + count[15:0];
          wr_data <= {hi, lo};
          if (count == LAST_IDX) begin
            state <= DONE;
          end else begin
            count      <= count + 17'd1;
            state      <= LOAD_HI;
            byte_ready <= 1'b1;
          end
        end
        DONE: begin
          byte_ready <= 1'b0;
          done       <= 1'b1;
          cpu_en     <= 1'b1;
        end
        default: begin
          state      <= LOAD_HI;
          byte_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_loader
//  Description : Self-checking bench for ram_loader with a byte-count based
//                reference model and a per-cycle compare process.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_loader;

  localparam int          W    = 16;
  localparam logic [15:0] BASE = 16'hFFFE;

  logic        clk;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        cpu_en;
  logic        done;

  logic [7:0]  b_byte_in;
  logic        b_byte_valid;
  logic        b_byte_ready;
  logic        b_wr_en;
  logic [15:0] b_wr_addr;
  logic [15:0] b_wr_data;
  logic        b_cpu_en;
  logic        b_done;

  int checks   = 0;
  int failures = 0;

  ram_loader #(.WORDS(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cpu_en(cpu_en), .done(done)
  );

  ram_loader #(.WORDS(2), .BASE_ADDR(16'h0000)) dut_b (
    .clk(clk), .rst(rst), .byte_in(b_byte_in), .byte_valid(b_byte_valid),
    .byte_ready(b_byte_ready), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .cpu_en(b_cpu_en), .done(b_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // ---------------- reference model (byte-count view) ----------------
  logic [7:0]  q[$];
  int          nb;
  bit          stall;
  bit          fin;
  bit          armed = 1'b0;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [15:0] m_data;
  logic        m_done;

  function automatic logic m_ready();
    return !stall && (nb < 2 * W);
  endfunction

  // Model: bytes are consumed while fewer than 2*W have arrived, except for
  // the one cycle after each completed word; that word shows up as a write
  // on the following edge, and completion is flagged one edge after the last.
  always @(posedge clk) begin
    if (!rst) begin
      q.delete();
      nb     = 0;
      stall  = 1'b0;
      fin    = 1'b0;
      m_wr   = 1'b0;
      m_addr = BASE;
      m_data = 16'h0000;
      m_done = 1'b0;
      armed  = 1'b1;
    end else if (armed) begin
      m_wr = 1'b0;
      if (fin) begin
        m_done = 1'b1;
        fin    = 1'b0;
      end
      if (stall) begin
        m_wr   = 1'b1;
        m_addr = 16'(BASE + 16'(nb / 2 - 1));
        m_data = {q[nb-2], q[nb-1]};
        stall  = 1'b0;
        if (nb == 2 * W) fin = 1'b1;
      end else if (m_ready() && byte_valid) begin
        q.push_back(byte_in);
        nb++;
        if (nb % 2 == 0) stall = 1'b1;
      end
    end
  end

  // Compare process: every output checked on every falling edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("byte_ready", {31'd0, byte_ready}, {31'd0, m_ready()});
      chk("wr_en",      {31'd0, wr_en},      {31'd0, m_wr});
      chk("wr_addr",    {16'd0, wr_addr},    {16'd0, m_addr});
      chk("wr_data",    {16'd0, wr_data},    {16'd0, m_data});
      chk("done",       {31'd0, done},       {31'd0, m_done});
      chk("cpu_en",     {31'd0, cpu_en},     {31'd0, m_done});
    end
  end

  // Write logs for literal checks.
  logic [31:0] wlog[$];
  logic [31:0] b_log[$];
  int          b_wcyc[$];
  int          cyc        = 0;
  int          b_done_cyc = -1;
  int          b_cpu_cyc  = -1;

  always @(negedge clk) begin
    cyc++;
    if (wr_en) wlog.push_back({wr_addr, wr_data});
    if (b_wr_en) begin
      b_log.push_back({b_wr_addr, b_wr_data});
      b_wcyc.push_back(cyc);
    end
    if (b_done && b_done_cyc < 0) b_done_cyc = cyc;
    if (b_cpu_en && b_cpu_cyc < 0) b_cpu_cyc = cyc;
  end

  // Present one byte after a gap, hold it until accepted (bounded).
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept", {31'd0, byte_ready}, 32'd1);
    @(negedge clk);
  endtask

  logic [15:0] sent[$];

  task automatic send_word(input logic [15:0] w, input int gap);
    sent.push_back(w);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  initial begin
    logic [7:0] arr [4];
    int i;
    int n;
    bit xf;
    logic [15:0] w;

    rst          = 1'b0;
    byte_in      = 8'h00;
    byte_valid   = 1'b0;
    b_byte_in    = 8'h00;
    b_byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset state literals
    chk("rst_ready",  {31'd0, byte_ready}, 32'd1);
    chk("rst_addr",   {16'd0, wr_addr},    32'h0000FFFE);
    chk("rst_data",   {16'd0, wr_data},    32'd0);
    chk("rst_cpu_en", {31'd0, cpu_en},     32'd0);

    // Two-word back-to-back load on the small instance
    arr = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    i = 0;
    for (int c = 0; c < 30 && i < 4; c++) begin
      b_byte_in    = arr[i];
      b_byte_valid = 1'b1;
      xf = b_byte_ready;
      @(negedge clk);
      if (xf) i++;
    end
    b_byte_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("b_nwrites", b_log.size(), 32'd2);
    chk("b_write0",  b_log[0], 32'h00001234);
    chk("b_write1",  b_log[1], 32'h0001ABCD);
    chk("b_spacing", 32'(b_wcyc[1] - b_wcyc[0]), 32'd3);
    chk("b_done_at", 32'(b_done_cyc - b_wcyc[1]), 32'd1);
    chk("b_cpu_at",  32'(b_cpu_cyc - b_wcyc[1]), 32'd1);

    // Main instance: two words, then reset after the next high byte
    for (int k = 0; k < 2; k++) send_word(16'($urandom), $urandom_range(0, 5));
    send_byte(8'($urandom), 0);
    byte_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wlog.delete();
    sent.delete();

    // Full load: 5AA5 first, continuous valid, then random gaps
    send_word(16'h5AA5, 0);
    for (int k = 1; k < W; k++) begin
      w = 16'($urandom);
      send_word(w, (k <= 8) ? 0 : $urandom_range(0, 5));
    end
    byte_valid = 1'b0;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", {31'd0, done}, 32'd1);
    chk("nwrites",      wlog.size(), 32'd16);
    chk("first_write",  wlog[0], 32'hFFFE5AA5);
    chk("addr1",        {16'd0, wlog[1][31:16]}, 32'h0000FFFF);
    chk("addr2",        {16'd0, wlog[2][31:16]}, 32'h00000000);
    for (int k = 0; k < W; k++) chk("scoreboard", {16'd0, wlog[k][15:0]}, {16'd0, sent[k]});

    // Bytes offered after completion are ignored
    byte_in    = 8'h77;
    byte_valid = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_done_writes", wlog.size(), 32'd16);
    chk("post_done_cpu",    {31'd0, cpu_en}, 32'd1);
    chk("post_done_ready",  {31'd0, byte_ready}, 32'd0);

    // Reset while done stops the CPU again
    byte_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rst_done_cpu", {31'd0, cpu_en}, 32'd0);
    chk("rst_done",     {31'd0, done},   32'd0);

    // Reset during the write cycle suppresses the write
    send_word(16'hBEEF, 0);
    byte_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_write", wlog.size(), 32'd16);

    // A short random load after that to confirm restart from BASE
    send_word(16'($urandom), $urandom_range(0, 3));
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("restart_addr", {16'd0, wlog[16][31:16]}, 32'h0000FFFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
